// File: rtl/round_robin_arbiter_4.sv
// Four-way round-robin arbiter with a per-owner hold limit and one idle cycle on every handover.
// Latency: i_req sampled at edge N drives o_gnt right after edge N; release takes effect at the next edge.
// Backpressure: none inside; requesters hold i_req until served, and the owner releases by dropping its bit.
module round_robin_arbiter_4 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic [3:0] i_req,
   output logic [3:0] o_gnt,
   output logic [1:0] o_gnt_id,
   output logic       o_busy,
   output logic       o_timeout
);

   localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    gnt_id_q, gnt_id_d;
   logic [1:0]    last_id_q, last_id_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;
   logic          timeout_q, timeout_d;

   logic [1:0]    pick_id;
   logic          pick_vld;
   logic          hold_done;
   logic          release_now;

   // Scan requests starting just past the previous owner, wrapping round to it last.
   always_comb begin
      pick_id  = 2'd0;
      pick_vld = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         if (!pick_vld && i_req[last_id_q + 2'(k)]) begin
            pick_id  = last_id_q + 2'(k);
            pick_vld = 1'b1;
         end
      end
   end

   assign hold_done   = (hold_cnt_q == HOLD_LAST);
   assign release_now = !i_req[gnt_id_q] || !i_en || hold_done;

   // Next-state logic: grant from IDLE, hold in GRANT until any release condition.
   always_comb begin
      state_d    = state_q;
      gnt_id_d   = gnt_id_q;
      last_id_d  = last_id_q;
      hold_cnt_d = hold_cnt_q;
      timeout_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            hold_cnt_d = '0;
            if (i_en && pick_vld) begin
               state_d  = ST_GRANT;
               gnt_id_d = pick_id;
            end
         end
         ST_GRANT: begin
            if (release_now) begin
               state_d    = ST_IDLE;
               last_id_d  = gnt_id_q;
               hold_cnt_d = '0;
               // Timeout is flagged even when the owner also dropped or enable fell.
               timeout_d  = hold_done;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset; requester 0 gets first priority.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         gnt_id_q   <= 2'd0;
         last_id_q  <= 2'd3;
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_id_q   <= gnt_id_d;
         last_id_q  <= last_id_d;
         hold_cnt_q <= hold_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_busy    = (state_q == ST_GRANT);
   assign o_gnt_id  = gnt_id_q;
   assign o_gnt     = o_busy ? (4'b0001 << gnt_id_q) : 4'b0000;
   assign o_timeout = timeout_q;

endmodule

// File: tb/tb_round_robin_arbiter_4.sv
// Bench for round_robin_arbiter_4 with MAX_HOLD=4: directed sequences plus a per-cycle reference model.
// Latency: each step applies inputs, waits one edge, then checks the resulting outputs.
// Backpressure: not applicable; the bench drives request levels directly.
module tb_round_robin_arbiter_4;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] req;
   logic [3:0] o_gnt;
   logic [1:0] o_gnt_id;
   logic       o_busy;
   logic       o_timeout;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   round_robin_arbiter_4 #(.MAX_HOLD(MAXH)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_en      (en),
      .i_req     (req),
      .o_gnt     (o_gnt),
      .o_gnt_id  (o_gnt_id),
      .o_busy    (o_busy),
      .o_timeout (o_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: owner index (-1 = nobody), previous owner, cycles owned so far.
   int       m_owner = -1;
   int       m_last  = 3;
   int       m_owned = 0;
   bit       m_to    = 1'b0;
   int       m_c;
   bit       m_exp;
   logic [3:0] m_gnt;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_owner = -1;
         m_last  = 3;
         m_owned = 0;
         m_to    = 1'b0;
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         if (en) begin
            for (int k = 1; k <= 4; k++) begin
               m_c = (m_last + k) % 4;
               if (m_owner < 0 && req[m_c]) begin
                  m_owner = m_c;
                  m_owned = 1;
               end
            end
         end
      end else begin
         m_exp = (m_owned == MAXH);
         if (!req[m_owner] || !en || m_exp) begin
            m_to    = m_exp;
            m_last  = m_owner;
            m_owner = -1;
         end else begin
            m_owned++;
            m_to = 1'b0;
         end
      end
   end

   // Compare DUT against the model, plus structural invariants, on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         m_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
         check("mdl_busy", 32'(o_busy), 32'(m_owner >= 0));
         check("mdl_gnt", 32'(o_gnt), 32'(m_gnt));
         check("mdl_timeout", 32'(o_timeout), 32'(m_to));
         if (m_owner >= 0)
            check("mdl_gnt_id", 32'(o_gnt_id), 32'(m_owner[1:0]));
         check("inv_onehot0", 32'($onehot0(o_gnt)), 32'd1);
         check("inv_busy", 32'(o_busy), 32'(o_gnt != 4'b0000));
         if (o_busy)
            check("inv_decode", 32'(o_gnt), 32'(4'b0001 << o_gnt_id));
      end
   end

   // Apply inputs, let one edge pass, then check grant and timeout against hand values.
   task automatic step(input logic e, input logic [3:0] r, input logic [3:0] eg,
                       input logic et, input string nm);
      en  = e;
      req = r;
      @(posedge clk);
      #1;
      check({nm, "_gnt"}, 32'(o_gnt), 32'(eg));
      check({nm, "_to"}, 32'(o_timeout), 32'(et));
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt", 32'(o_gnt), 32'h0);
      check("rst_gnt_id", 32'(o_gnt_id), 32'h0);
      check("rst_busy", 32'(o_busy), 32'h0);
      check("rst_timeout", 32'(o_timeout), 32'h0);
      chk_en = 1'b1;
      rst_n  = 1'b1;

      // Rotation with all requesting, each owner dropping after two grant cycles.
      step(1'b1, 4'b1111, 4'b0001, 1'b0, "rot0a");
      step(1'b1, 4'b1111, 4'b0001, 1'b0, "rot0b");
      step(1'b1, 4'b1110, 4'b0000, 1'b0, "rot0r");
      step(1'b1, 4'b1111, 4'b0010, 1'b0, "rot1a");
      step(1'b1, 4'b1111, 4'b0010, 1'b0, "rot1b");
      step(1'b1, 4'b1101, 4'b0000, 1'b0, "rot1r");
      step(1'b1, 4'b1111, 4'b0100, 1'b0, "rot2a");
      step(1'b1, 4'b1111, 4'b0100, 1'b0, "rot2b");
      step(1'b1, 4'b1011, 4'b0000, 1'b0, "rot2r");
      step(1'b1, 4'b1111, 4'b1000, 1'b0, "rot3a");
      step(1'b1, 4'b1111, 4'b1000, 1'b0, "rot3b");
      step(1'b1, 4'b0111, 4'b0000, 1'b0, "rot3r");
      step(1'b1, 4'b1111, 4'b0001, 1'b0, "rot4a");
      step(1'b1, 4'b0000, 4'b0000, 1'b0, "rot4r");
      step(1'b1, 4'b0000, 4'b0000, 1'b0, "idle0");

      // Single requester held: timeout, one idle cycle, then re-granted.
      for (int i = 0; i < MAXH; i++)
         step(1'b1, 4'b0100, 4'b0100, 1'b0, "solo_hold");
      step(1'b1, 4'b0100, 4'b0000, 1'b1, "solo_to");
      step(1'b1, 4'b0100, 4'b0100, 1'b0, "solo_regnt");
      step(1'b1, 4'b0000, 4'b0000, 1'b0, "solo_drop");

      // Two requesters held: timeouts hand priority across by rotation.
      for (int i = 0; i < MAXH; i++)
         step(1'b1, 4'b0011, 4'b0001, 1'b0, "pair_h0");
      step(1'b1, 4'b0011, 4'b0000, 1'b1, "pair_to0");
      for (int i = 0; i < MAXH; i++)
         step(1'b1, 4'b0011, 4'b0010, 1'b0, "pair_h1");
      step(1'b1, 4'b0011, 4'b0000, 1'b1, "pair_to1");
      step(1'b1, 4'b0011, 4'b0001, 1'b0, "pair_back0");
      step(1'b1, 4'b0000, 4'b0000, 1'b0, "pair_drop");

      // Enable gating: blocks new grants and revokes without a timeout pulse.
      step(1'b0, 4'b1010, 4'b0000, 1'b0, "en_off0");
      step(1'b0, 4'b1010, 4'b0000, 1'b0, "en_off1");
      step(1'b1, 4'b1010, 4'b0010, 1'b0, "en_on");
      step(1'b1, 4'b1010, 4'b0010, 1'b0, "en_hold");
      step(1'b0, 4'b1010, 4'b0000, 1'b0, "en_revoke");
      step(1'b0, 4'b1010, 4'b0000, 1'b0, "en_idle");

      // Timeout coinciding with the owner dropping its request still pulses.
      for (int i = 0; i < MAXH; i++)
         step(1'b1, 4'b0010, 4'b0010, 1'b0, "tod_hold");
      step(1'b1, 4'b0000, 4'b0000, 1'b1, "tod_to");
      step(1'b1, 4'b0000, 4'b0000, 1'b0, "tod_after");

      // Reset while requester 3 owns the bus.
      step(1'b1, 4'b1000, 4'b1000, 1'b0, "pre_rst_a");
      step(1'b1, 4'b1000, 4'b1000, 1'b0, "pre_rst_b");
      rst_n = 1'b0;
      step(1'b1, 4'b1000, 4'b0000, 1'b0, "mid_rst");
      check("mid_rst_busy", 32'(o_busy), 32'h0);
      check("mid_rst_gnt_id", 32'(o_gnt_id), 32'h0);
      rst_n = 1'b1;
      step(1'b1, 4'b1001, 4'b0001, 1'b0, "post_rst");

      // A request pulse during another owner's grant is not remembered.
      step(1'b1, 4'b1011, 4'b0001, 1'b0, "flash_on");
      step(1'b1, 4'b1001, 4'b0001, 1'b0, "flash_off");
      step(1'b1, 4'b0000, 4'b0000, 1'b0, "flash_rel");
      step(1'b1, 4'b0000, 4'b0000, 1'b0, "flash_none");
      step(1'b1, 4'b0000, 4'b0000, 1'b0, "flash_none2");

      @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
